rwm_frame_ctrl: RTL

Frame-level sequencer for the RGB read/write memory (RWM). It optionally clears the RWM, then arms on the camera's frame-start pulse and launches a full-frame WRITE. After the write it launches a full-frame READ toward the grayscaler and signals frame completion to the top-level controller. A watchdog aborts any phase that stalls, and the block counts completed frames.

---
 rtl/rwm_ctrl_pkg.sv | 31 +++
 rtl/rwm_watchdog.sv | 37 +++
 rtl/rwm_frame_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rwm_ctrl_pkg.sv
// Shared types and defaults for the RWM frame sequencer: state encoding,
// RWM opcode values and default counter widths.
package rwm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ARM,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_FAULT
  } state_e;

  localparam logic RWM_OP_WRITE = 1'b1;
  localparam logic RWM_OP_READ  = 1'b0;

  localparam int TIMEOUT_W_DEF = 21;
  localparam int FCNT_W_DEF    = 16;

  // States in which a phase is waiting on a completion event.
  function automatic logic is_watched(state_e s);
    return (s == ST_CLEAR) || (s == ST_WRITE) || (s == ST_READ) || (s == ST_DRAIN);
  endfunction

  // States whose first cycle launches an RWM operation.
  function automatic logic is_launch(state_e s);
    return (s == ST_CLEAR) || (s == ST_WRITE) || (s == ST_READ);
  endfunction

endpackage

// File: rtl/rwm_watchdog.sv
// Saturating phase watchdog: clr reloads zero, en counts, expired flags the
// cycle in which the count steps onto all-ones.
module rwm_watchdog #(
  parameter int W = 21
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Independent of clr so the FSM can use it to pick its next state.
  assign expired = en && (cnt_q >= (MAX - W'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rwm_frame_ctrl.sv
// Frame sequencer for the RGB RWM: [clear] -> arm -> write -> read -> drain.
// Define RWM_FRAME_CTRL_CLEAR_EN to run a CLEAR phase before every frame.
module rwm_frame_ctrl
  import rwm_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = TIMEOUT_W_DEF,
  parameter int FCNT_W    = FCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cam_frame_start,
  input  logic              rwm_done,
  input  logic              gray_done,
  input  logic              abort,
  output logic              rwm_enable,
  output logic              rwm_rw,
  output logic              rwm_clear,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err,
  output logic [FCNT_W-1:0] frame_count
);

  state_e state_q, state_d;

  logic              wd_expired;
  logic              state_entry;
  logic              launch;
  logic              gray_seen_q, gray_seen_d;
  logic              rwm_enable_q, rwm_enable_d;
  logic              rwm_rw_q, rwm_rw_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              timeout_err_q, timeout_err_d;
  logic [FCNT_W-1:0] frame_count_q, frame_count_d;

  rwm_watchdog #(
    .W (TIMEOUT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_entry),
    .en      (is_watched(state_q)),
    .expired (wd_expired)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
`ifdef RWM_FRAME_CTRL_CLEAR_EN
            state_d = ST_CLEAR;
`else
            state_d = ST_ARM;
`endif
          end
        end
`ifdef RWM_FRAME_CTRL_CLEAR_EN
        ST_CLEAR: begin
          if (wd_expired)    state_d = ST_FAULT;
          else if (rwm_done) state_d = ST_ARM;
        end
`endif
        ST_ARM: begin
          if (cam_frame_start) state_d = ST_WRITE;
        end
        ST_WRITE: begin
          if (wd_expired)    state_d = ST_FAULT;
          else if (rwm_done) state_d = ST_READ;
        end
        ST_READ: begin
          if (wd_expired)    state_d = ST_FAULT;
          else if (rwm_done) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (wd_expired)                    state_d = ST_FAULT;
          else if (gray_done || gray_seen_q) state_d = ST_IDLE;
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign state_entry = (state_d != state_q);
  assign launch      = state_entry && is_launch(state_d);

  always_comb begin
    rwm_enable_d  = launch;
    rwm_rw_d      = rwm_rw_q;
    busy_d        = (state_d != ST_IDLE) && (state_d != ST_FAULT);
    frame_done_d  = (state_q == ST_DRAIN) && (state_d == ST_IDLE) && !abort;
    frame_count_d = frame_count_q;
    timeout_err_d = timeout_err_q;
    // A gray_done arriving with the final rwm_done lets DRAIN finish at once.
    gray_seen_d   = (state_q == ST_READ) && (state_d == ST_DRAIN) && gray_done;

    if (state_d == ST_FAULT) begin
      rwm_rw_d = 1'b0;
    end else if (launch && (state_d == ST_WRITE)) begin
      rwm_rw_d = RWM_OP_WRITE;
    end else if (launch && (state_d == ST_READ)) begin
      rwm_rw_d = RWM_OP_READ;
    end

    if (frame_done_d) begin
      frame_count_d = frame_count_q + FCNT_W'(1);
    end

    if (abort) begin
      timeout_err_d = 1'b0;
    end else if ((state_d == ST_FAULT) && (state_q != ST_FAULT)) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gray_seen_q   <= 1'b0;
      rwm_enable_q  <= 1'b0;
      rwm_rw_q      <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      gray_seen_q   <= gray_seen_d;
      rwm_enable_q  <= rwm_enable_d;
      rwm_rw_q      <= rwm_rw_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      frame_count_q <= frame_count_d;
    end
  end

`ifdef RWM_FRAME_CTRL_CLEAR_EN
  logic rwm_clear_q, rwm_clear_d;

  always_comb begin
    rwm_clear_d = launch && (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rwm_clear_q <= 1'b0;
    end else begin
      rwm_clear_q <= rwm_clear_d;
    end
  end

  assign rwm_clear = rwm_clear_q;
`else
  assign rwm_clear = 1'b0;
`endif

  assign rwm_enable  = rwm_enable_q;
  assign rwm_rw      = rwm_rw_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign frame_count = frame_count_q;

endmodule
